// File: rtl/bcpu_defs_pkg.sv
// -----------------------------------------------------------------------------
// bcpu_defs
//   Shared definitions for the BCPU16 front end.
//   - Default widths of the fetch stage parameters.
//   - fb_kind_e: how a next-PC feedback word resolves (none / jump / repeat).
//   - fetch_fb_t: packed next-PC feedback bundle at the default widths, for
//     blocks that move feedback around as a single word.
//   - fb_decode(): priority decode of a feedback word (jump beats repeat).
// -----------------------------------------------------------------------------
package bcpu_defs;

  localparam int PC_WIDTH_DEFAULT           = 10;
  localparam int INSTR_WIDTH_DEFAULT        = 16;
  localparam int THREAD_INDEX_WIDTH_DEFAULT = 2;

  typedef enum logic [1:0] {
    FB_KIND_NONE   = 2'd0,  // no PC change, sequential advance stands
    FB_KIND_JUMP   = 2'd1,  // taken jump/call, target is the jump address
    FB_KIND_REPEAT = 2'd2   // re-execute the instruction at the feedback PC
  } fb_kind_e;

  typedef struct packed {
    logic                                  valid;
    logic [THREAD_INDEX_WIDTH_DEFAULT-1:0] thread;
    logic [PC_WIDTH_DEFAULT-1:0]           pc;
    logic                                  jmp_en;
    logic [PC_WIDTH_DEFAULT-1:0]           jmp_addr;
    logic                                  repeat_en;
  } fetch_fb_t;

  // Jump has priority over repeat when both are flagged.
  function automatic fb_kind_e fb_decode(input logic valid,
                                         input logic jmp_en,
                                         input logic repeat_en);
    fb_kind_e kind;
    kind = FB_KIND_NONE;
    if (valid) begin
      if (jmp_en) begin
        kind = FB_KIND_JUMP;
      end else if (repeat_en) begin
        kind = FB_KIND_REPEAT;
      end
    end
    return kind;
  endfunction

endpackage

// File: rtl/bcpu_thread_pc_regs.sv
// -----------------------------------------------------------------------------
// bcpu_thread_pc_regs
//   Per-thread program counter register file (1 << THREAD_INDEX_WIDTH entries).
//   Ports:
//     clk, rst_n        clock, synchronous active-low reset (all PCs -> RESET_PC)
//     rd_idx / rd_pc    asynchronous read port (thread being issued)
//     issue_wr_*        write port used by the issuing thread
//     fb_wr_*           write port used by feedback aimed at another thread
//   The fetch stage guarantees the two write ports never target the same entry
//   in one cycle (same-thread feedback is folded into the issue write). Should
//   they ever collide, the issue write takes precedence.
// -----------------------------------------------------------------------------
module bcpu_thread_pc_regs
  import bcpu_defs::*;
#(
  parameter int                PC_WIDTH           = PC_WIDTH_DEFAULT,
  parameter int                THREAD_INDEX_WIDTH = THREAD_INDEX_WIDTH_DEFAULT,
  parameter logic [PC_WIDTH-1:0] RESET_PC         = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [THREAD_INDEX_WIDTH-1:0] rd_idx,
  output logic [PC_WIDTH-1:0]           rd_pc,
  input  logic                          issue_wr_en,
  input  logic [THREAD_INDEX_WIDTH-1:0] issue_wr_idx,
  input  logic [PC_WIDTH-1:0]           issue_wr_pc,
  input  logic                          fb_wr_en,
  input  logic [THREAD_INDEX_WIDTH-1:0] fb_wr_idx,
  input  logic [PC_WIDTH-1:0]           fb_wr_pc
);

  localparam int NUM_THREADS = 1 << THREAD_INDEX_WIDTH;

  logic [PC_WIDTH-1:0] pc_q [NUM_THREADS];
  logic [PC_WIDTH-1:0] pc_d [NUM_THREADS];

  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      pc_d[i] = pc_q[i];
      if (fb_wr_en && (fb_wr_idx == THREAD_INDEX_WIDTH'(i))) begin
        pc_d[i] = fb_wr_pc;
      end
      if (issue_wr_en && (issue_wr_idx == THREAD_INDEX_WIDTH'(i))) begin
        pc_d[i] = issue_wr_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (!rst_n) begin
        pc_q[i] <= RESET_PC;
      end else begin
        pc_q[i] <= pc_d[i];
      end
    end
  end

  assign rd_pc = pc_q[rd_idx];

endmodule

// File: rtl/bcpu_fetch_stage.sv
// -----------------------------------------------------------------------------
// bcpu_fetch_stage
//   Barrel instruction fetch: one PC per hardware thread, strict round-robin
//   issue (one thread per CE cycle), synchronous program BRAM read, and
//   per-thread next-PC feedback from execute (jump, repeat, or sequential).
//   Ports:
//     CLK, RESET_N, CE          clock, synchronous active-low reset, enable
//     PROG_ADDR/RD_EN/DATA      program BRAM read port (1-cycle latency)
//     INSTR_OUT/PC_OUT/
//     THREAD_OUT/INSTR_VALID    fetched instruction to the decoder
//     FB_*                      next-PC feedback from the execute stage
// -----------------------------------------------------------------------------
module bcpu_fetch_stage
  import bcpu_defs::*;
#(
  parameter int                  PC_WIDTH           = PC_WIDTH_DEFAULT,
  parameter int                  INSTR_WIDTH        = INSTR_WIDTH_DEFAULT,
  parameter int                  THREAD_INDEX_WIDTH = THREAD_INDEX_WIDTH_DEFAULT,
  parameter logic [PC_WIDTH-1:0] RESET_PC           = '0
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          CE,
  output logic [PC_WIDTH-1:0]           PROG_ADDR,
  output logic                          PROG_RD_EN,
  input  logic [INSTR_WIDTH-1:0]        PROG_DATA,
  output logic [INSTR_WIDTH-1:0]        INSTR_OUT,
  output logic [PC_WIDTH-1:0]           PC_OUT,
  output logic [THREAD_INDEX_WIDTH-1:0] THREAD_OUT,
  output logic                          INSTR_VALID,
  input  logic                          FB_VALID,
  input  logic [THREAD_INDEX_WIDTH-1:0] FB_THREAD,
  input  logic [PC_WIDTH-1:0]           FB_PC,
  input  logic                          FB_JMP_EN,
  input  logic [PC_WIDTH-1:0]           FB_JMP_ADDR,
  input  logic                          FB_REPEAT
);

  // Round-robin pointer and decoder-facing output registers.
  logic [THREAD_INDEX_WIDTH-1:0] cur_q, cur_d;
  logic [PC_WIDTH-1:0]           pc_q, pc_d;
  logic [THREAD_INDEX_WIDTH-1:0] thread_q, thread_d;
  logic                          valid_q, valid_d;

  logic                          active;
  fb_kind_e                      fb_kind;
  logic                          fb_changes_pc;
  logic [PC_WIDTH-1:0]           fb_target;
  logic                          fb_to_cur;
  logic                          fb_wr_en;
  logic [PC_WIDTH-1:0]           rd_pc;
  logic [PC_WIDTH-1:0]           issue_pc;
  logic [PC_WIDTH-1:0]           issue_next_pc;

  bcpu_thread_pc_regs #(
    .PC_WIDTH           (PC_WIDTH),
    .THREAD_INDEX_WIDTH (THREAD_INDEX_WIDTH),
    .RESET_PC           (RESET_PC)
  ) u_pc_regs (
    .clk          (CLK),
    .rst_n        (RESET_N),
    .rd_idx       (cur_q),
    .rd_pc        (rd_pc),
    .issue_wr_en  (active),
    .issue_wr_idx (cur_q),
    .issue_wr_pc  (issue_next_pc),
    .fb_wr_en     (fb_wr_en),
    .fb_wr_idx    (FB_THREAD),
    .fb_wr_pc     (fb_target)
  );

  always_comb begin
    active        = CE & RESET_N;
    fb_kind       = fb_decode(FB_VALID, FB_JMP_EN, FB_REPEAT);
    fb_changes_pc = (fb_kind != FB_KIND_NONE);
    fb_target     = (fb_kind == FB_KIND_JUMP) ? FB_JMP_ADDR : FB_PC;

    // Feedback aimed at the thread issuing right now bypasses the register
    // file; its sequential successor is then written through the issue port,
    // so each thread sees at most one write per cycle.
    fb_to_cur     = fb_changes_pc && (FB_THREAD == cur_q);
    issue_pc      = fb_to_cur ? fb_target : rd_pc;
    issue_next_pc = issue_pc + PC_WIDTH'(1);
    fb_wr_en      = active && fb_changes_pc && !fb_to_cur;

    cur_d    = cur_q;
    pc_d     = pc_q;
    thread_d = thread_q;
    valid_d  = 1'b0;
    if (active) begin
      cur_d    = cur_q + THREAD_INDEX_WIDTH'(1);
      pc_d     = issue_pc;
      thread_d = cur_q;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cur_q    <= '0;
      pc_q     <= '0;
      thread_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      cur_q    <= cur_d;
      pc_q     <= pc_d;
      thread_q <= thread_d;
      valid_q  <= valid_d;
    end
  end

  // Outputs are forced quiet for as long as reset is asserted, not only
  // after the first reset edge.
  always_comb begin
    PROG_RD_EN  = active;
    PROG_ADDR   = RESET_N ? issue_pc : RESET_PC;
    INSTR_VALID = valid_q & RESET_N;
    INSTR_OUT   = INSTR_VALID ? PROG_DATA : '0;
    PC_OUT      = RESET_N ? pc_q : '0;
    THREAD_OUT  = RESET_N ? thread_q : '0;
  end

endmodule

// File: tb/tb_bcpu_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_bcpu_fetch_stage
//   Drives directed scenarios followed by random stimulus and compares every
//   cycle against a transaction-level model: each enabled cycle first applies
//   any feedback to the model thread PC table, then fetches the current
//   thread's PC, advances it and moves to the next thread.
// -----------------------------------------------------------------------------
module tb_bcpu_fetch_stage;

  localparam int PCW = 10;
  localparam int IW  = 16;
  localparam int TIW = 2;
  localparam int NT  = 1 << TIW;
  localparam int PC_MOD = 1 << PCW;
  localparam logic [PCW-1:0] RST_PC = '0;

  logic           clk;
  logic           rst_n;
  logic           ce;
  logic [PCW-1:0] prog_addr;
  logic           prog_rd_en;
  logic [IW-1:0]  prog_data;
  logic [IW-1:0]  instr_out;
  logic [PCW-1:0] pc_out;
  logic [TIW-1:0] thread_out;
  logic           instr_valid;
  logic           fb_valid;
  logic [TIW-1:0] fb_thread;
  logic [PCW-1:0] fb_pc;
  logic           fb_jmp_en;
  logic [PCW-1:0] fb_jmp_addr;
  logic           fb_repeat;

  bcpu_fetch_stage #(
    .PC_WIDTH           (PCW),
    .INSTR_WIDTH        (IW),
    .THREAD_INDEX_WIDTH (TIW),
    .RESET_PC           (RST_PC)
  ) dut (
    .CLK         (clk),
    .RESET_N     (rst_n),
    .CE          (ce),
    .PROG_ADDR   (prog_addr),
    .PROG_RD_EN  (prog_rd_en),
    .PROG_DATA   (prog_data),
    .INSTR_OUT   (instr_out),
    .PC_OUT      (pc_out),
    .THREAD_OUT  (thread_out),
    .INSTR_VALID (instr_valid),
    .FB_VALID    (fb_valid),
    .FB_THREAD   (fb_thread),
    .FB_PC       (fb_pc),
    .FB_JMP_EN   (fb_jmp_en),
    .FB_JMP_ADDR (fb_jmp_addr),
    .FB_REPEAT   (fb_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory with one-cycle registered read.
  logic [IW-1:0] mem [PC_MOD];
  always @(posedge clk) begin
    if (prog_rd_en) prog_data <= mem[prog_addr];
  end

  // Reference model state.
  int m_pc [NT];
  int m_cur;
  bit m_valid;
  int m_out_pc;
  int m_out_thr;

  int n_cmp;
  int n_bad;
  int cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: apply inputs at the falling edge, check, advance model.
  task automatic step(input bit r, input bit c, input bit fv, input int ft,
                      input int fp, input bit fj, input int fja, input bit fr);
    bit exp_valid;
    int npc;
    bit fb_moves;
    @(negedge clk);
    rst_n       = r;
    ce          = c;
    fb_valid    = fv;
    fb_thread   = TIW'(ft);
    fb_pc       = PCW'(fp);
    fb_jmp_en   = fj;
    fb_jmp_addr = PCW'(fja);
    fb_repeat   = fr;
    #1;
    cyc++;

    exp_valid = r && m_valid;
    check("instr_valid", 32'(instr_valid), 32'(exp_valid));
    check("instr_out",   32'(instr_out),   exp_valid ? 32'(mem[m_out_pc]) : 32'd0);
    check("pc_out",      32'(pc_out),      r ? 32'(m_out_pc) : 32'd0);
    check("thread_out",  32'(thread_out),  r ? 32'(m_out_thr) : 32'd0);
    check("prog_rd_en",  32'(prog_rd_en),  32'(r && c));

    fb_moves = fv && (fj || fr);
    if (!r) begin
      check("prog_addr_rst", 32'(prog_addr), 32'(RST_PC));
      for (int t = 0; t < NT; t++) m_pc[t] = int'(RST_PC);
      m_cur = 0; m_valid = 0; m_out_pc = 0; m_out_thr = 0;
    end else if (c) begin
      if (fb_moves) m_pc[ft] = fj ? fja : fp;
      npc = m_pc[m_cur];
      check("prog_addr", 32'(prog_addr), 32'(npc));
      $display("cyc %0d issue thr=%0d addr=0x%03h fb=%0b/%0d j=%0b r=%0b", cyc, m_cur, npc, fv, ft, fj, fr);
      m_pc[m_cur] = (npc + 1) % PC_MOD;
      m_out_pc  = npc;
      m_out_thr = m_cur;
      m_valid   = 1;
      m_cur     = (m_cur + 1) % NT;
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance until the model's round-robin pointer reaches target (bounded).
  task automatic sync_to(input int target);
    for (int i = 0; i < NT && m_cur != target; i++) idle(1);
    if (m_cur != target) check("sync_bound", 32'(m_cur), 32'(target));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    m_cur = 0; m_valid = 0; m_out_pc = 0; m_out_thr = 0;
    for (int t = 0; t < NT; t++) m_pc[t] = 0;
    for (int i = 0; i < PC_MOD; i++) mem[i] = IW'($urandom);
    rst_n = 0; ce = 0; fb_valid = 0; fb_thread = '0; fb_pc = '0;
    fb_jmp_en = 0; fb_jmp_addr = '0; fb_repeat = 0;

    // Reset, then plain round-robin sequential fetch.
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 2, 9, 1, 9, 0);
    idle(16);

    // Jump for thread 2 two cycles before its slot.
    sync_to(0);
    step(1, 1, 1, 2, 0, 1, 'h155, 0);
    idle(8);

    // Same-cycle repeat for the issuing thread (bypass).
    sync_to(1);
    step(1, 1, 1, 1, 5, 0, 0, 1);
    idle(8);

    // Jump and repeat together: jump wins.
    sync_to(3);
    step(1, 1, 1, 3, 7, 1, 'h20, 1);
    idle(8);

    // PC wrap at the top of the address space.
    sync_to(2);
    step(1, 1, 1, 0, 0, 1, 'h3FF, 0);
    idle(10);

    // CE low mid-stream (feedback ignored), then a one-cycle reset.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 1, 'h77, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    idle(8);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      int ja;
      ja = ($urandom_range(0, 3) == 0) ? (PC_MOD - 1) : int'($urandom_range(0, PC_MOD - 1));
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 2) == 0), int'($urandom_range(0, NT - 1)),
           int'($urandom_range(0, PC_MOD - 1)), bit'($urandom_range(0, 1)),
           ja, bit'($urandom_range(0, 1)));
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
